// File: rtl/uart_axi_pkg.sv
// Shared definitions for the UART Lite polling bridge: register map, STAT bits, AXI codes, FSM states.
package uart_axi_pkg;

    localparam logic [3:0]  REG_RX         = 4'h0;
    localparam logic [3:0]  REG_TX         = 4'h4;
    localparam logic [3:0]  REG_STAT       = 4'h8;
    localparam logic [3:0]  REG_CTRL       = 4'hC;

    localparam int          STAT_RX_VALID  = 0;
    localparam int          STAT_TX_FULL   = 3;

    localparam logic [1:0]  AXI_OKAY       = 2'b00;
    localparam logic [31:0] CTRL_RST_FIFOS = 32'h0000_0003;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_STAT_AR = 4'd1,
        ST_STAT_R  = 4'd2,
        ST_RX_AR   = 4'd3,
        ST_RX_R    = 4'd4,
        ST_TX_AW   = 4'd5,
        ST_TX_B    = 4'd6,
        ST_INIT    = 4'd7,
        ST_CTRL_AW = 4'd8,
        ST_CTRL_B  = 4'd9
    } state_e;

    typedef enum logic {
        RR_RX = 1'b0,
        RR_TX = 1'b1
    } rr_e;

    function automatic logic resp_err(input logic [1:0] resp);
        return (resp != AXI_OKAY);
    endfunction

endpackage

// File: rtl/uart_axi_bridge_fifo.sv
// Count-based synchronous FIFO with a registered head that already shows the first entry
// in the same cycle the FIFO becomes non-empty.
module sync_fifo #(
    parameter int  WIDTH = 8,
    parameter int  DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic [LW-1:0]    level,
    output logic             empty,
    output logic             full
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW-1:0]    rd_ptr_s;
    logic [LW-1:0]    level_r;
    logic [LW-1:0]    level_s;
    logic [LW-1:0]    after_pop_s;
    logic [WIDTH-1:0] head_r;
    logic [WIDTH-1:0] head_s;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign empty   = (level_r == {LW{1'b0}});
    assign full    = (level_r == LW'(DEPTH));
    assign level   = level_r;
    assign rd_data = head_r;

    // Legal push/pop qualification, next level and next head (bypass when the new entry becomes head)
    always_comb begin
        push_ok_s   = push & ~full;
        pop_ok_s    = pop & ~empty;
        rd_ptr_s    = rd_ptr_r;
        if (pop_ok_s) begin
            rd_ptr_s = rd_ptr_r + AW'(1);
        end else begin
            rd_ptr_s = rd_ptr_r;
        end
        after_pop_s = level_r - LW'(pop_ok_s);
        level_s     = after_pop_s + LW'(push_ok_s);
        if (push_ok_s && (after_pop_s == {LW{1'b0}})) begin
            head_s = wr_data;
        end else begin
            head_s = mem_r[rd_ptr_s];
        end
    end

    // Storage, pointers, occupancy and registered head
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            level_r  <= {LW{1'b0}};
            head_r   <= {WIDTH{1'b0}};
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= wr_data;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            rd_ptr_r <= rd_ptr_s;
            level_r  <= level_s;
            head_r   <= head_s;
        end
    end

endmodule

// File: rtl/uart_axi_bridge.sv
// AXI4-Lite master polling a UART Lite core, buffering RX/TX characters with round-robin service.
// Define UART_CTRL_INIT_EN to write CTRL=0x3 (flush UART FIFOs) once after reset.
module uart_axi_bridge
    import uart_axi_pkg::*;
#(
    parameter int  RX_DEPTH = 4,
    parameter int  TX_DEPTH = 4,
    parameter int  DATA_W   = 8,
    localparam int RX_LW    = $clog2(RX_DEPTH) + 1,
    localparam int TX_LW    = $clog2(TX_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rstn,
    output logic [3:0]        m_axi_araddr,
    output logic              m_axi_arvalid,
    input  logic              m_axi_arready,
    input  logic [31:0]       m_axi_rdata,
    input  logic [1:0]        m_axi_rresp,
    input  logic              m_axi_rvalid,
    output logic              m_axi_rready,
    output logic [3:0]        m_axi_awaddr,
    output logic              m_axi_awvalid,
    input  logic              m_axi_awready,
    output logic [31:0]       m_axi_wdata,
    output logic [3:0]        m_axi_wstrb,
    output logic              m_axi_wvalid,
    input  logic              m_axi_wready,
    input  logic [1:0]        m_axi_bresp,
    input  logic              m_axi_bvalid,
    output logic              m_axi_bready,
    output logic              rx_valid,
    output logic [DATA_W-1:0] rx_data,
    input  logic              rx_pop,
    output logic              tx_ready,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_push,
    output logic [RX_LW-1:0]  rx_level,
    output logic [TX_LW-1:0]  tx_level,
    output logic              axi_err
);

`ifdef UART_CTRL_INIT_EN
    localparam state_e RESET_STATE = ST_INIT;
`else
    localparam state_e RESET_STATE = ST_IDLE;
`endif

    state_e            state_r, state_s;
    rr_e               rr_last_r, rr_last_s;
    logic              arvalid_r, arvalid_s, rready_r, rready_s;
    logic [3:0]        araddr_r, araddr_s, awaddr_r, awaddr_s;
    logic              awvalid_r, awvalid_s, wvalid_r, wvalid_s, bready_r, bready_s;
    logic [31:0]       wdata_r, wdata_s;
    logic              axi_err_r, err_s;
    logic              r_hs_s, b_hs_s, rx_ok_s, tx_ok_s;
    logic              rx_push_s, tx_pop_s;
    logic              rx_empty_s, rx_full_s, tx_empty_s, tx_full_s;
    logic [DATA_W-1:0] tx_head_s;
    logic              unused_rdata_s;

    sync_fifo #(.WIDTH(DATA_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk(clk), .rstn(rstn), .push(rx_push_s), .wr_data(m_axi_rdata[DATA_W-1:0]),
        .pop(rx_pop), .rd_data(rx_data), .level(rx_level), .empty(rx_empty_s), .full(rx_full_s)
    );

    sync_fifo #(.WIDTH(DATA_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk(clk), .rstn(rstn), .push(tx_push), .wr_data(tx_data),
        .pop(tx_pop_s), .rd_data(tx_head_s), .level(tx_level), .empty(tx_empty_s), .full(tx_full_s)
    );

    assign unused_rdata_s = ^m_axi_rdata;

    // Poll/serve sequencer: next state and next AXI channel values
    always_comb begin
        state_s   = state_r;
        rr_last_s = rr_last_r;
        arvalid_s = arvalid_r;
        araddr_s  = araddr_r;
        rready_s  = rready_r;
        awvalid_s = awvalid_r;
        awaddr_s  = awaddr_r;
        wvalid_s  = wvalid_r;
        wdata_s   = wdata_r;
        bready_s  = bready_r;
        rx_push_s = 1'b0;
        tx_pop_s  = 1'b0;
        r_hs_s    = m_axi_rvalid & rready_r;
        b_hs_s    = m_axi_bvalid & bready_r;
        err_s     = (r_hs_s & resp_err(m_axi_rresp)) | (b_hs_s & resp_err(m_axi_bresp));
        rx_ok_s   = m_axi_rdata[STAT_RX_VALID] & ~rx_full_s;
        tx_ok_s   = ~m_axi_rdata[STAT_TX_FULL] & ~tx_empty_s;
        case (state_r)
            ST_INIT: begin
                awvalid_s = 1'b1;
                wvalid_s  = 1'b1;
                awaddr_s  = REG_CTRL;
                wdata_s   = CTRL_RST_FIFOS;
                state_s   = ST_CTRL_AW;
            end
            ST_IDLE: begin
                arvalid_s = 1'b1;
                araddr_s  = REG_STAT;
                state_s   = ST_STAT_AR;
            end
            ST_STAT_AR, ST_RX_AR: begin
                if (arvalid_r && m_axi_arready) begin
                    arvalid_s = 1'b0;
                    rready_s  = 1'b1;
                    state_s   = (state_r == ST_STAT_AR) ? ST_STAT_R : ST_RX_R;
                end else begin
                    state_s = state_r;
                end
            end
            ST_STAT_R: begin
                if (r_hs_s) begin
                    rready_s = 1'b0;
                    // RX wins a tie only when TX was served last
                    if (rx_ok_s && (!tx_ok_s || (rr_last_r == RR_TX))) begin
                        arvalid_s = 1'b1;
                        araddr_s  = REG_RX;
                        state_s   = ST_RX_AR;
                    end else if (tx_ok_s) begin
                        awvalid_s = 1'b1;
                        wvalid_s  = 1'b1;
                        awaddr_s  = REG_TX;
                        wdata_s   = 32'(tx_head_s);
                        state_s   = ST_TX_AW;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else begin
                    state_s = state_r;
                end
            end
            ST_RX_R: begin
                if (r_hs_s) begin
                    rready_s  = 1'b0;
                    rx_push_s = 1'b1;
                    rr_last_s = RR_RX;
                    state_s   = ST_IDLE;
                end else begin
                    state_s = state_r;
                end
            end
            ST_TX_AW, ST_CTRL_AW: begin
                awvalid_s = awvalid_r & ~m_axi_awready;
                wvalid_s  = wvalid_r & ~m_axi_wready;
                if (!awvalid_s && !wvalid_s) begin
                    bready_s = 1'b1;
                    state_s  = (state_r == ST_TX_AW) ? ST_TX_B : ST_CTRL_B;
                end else begin
                    state_s = state_r;
                end
            end
            ST_TX_B, ST_CTRL_B: begin
                if (b_hs_s) begin
                    bready_s = 1'b0;
                    state_s  = ST_IDLE;
                    if (state_r == ST_TX_B) begin
                        tx_pop_s  = 1'b1;
                        rr_last_s = RR_TX;
                    end else begin
                        tx_pop_s = 1'b0;
                    end
                end else begin
                    state_s = state_r;
                end
            end
            default: begin
                state_s   = ST_IDLE;
                arvalid_s = 1'b0;
                rready_s  = 1'b0;
                awvalid_s = 1'b0;
                wvalid_s  = 1'b0;
                bready_s  = 1'b0;
            end
        endcase
    end

    // State, AXI output registers and sticky error flag
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_r   <= RESET_STATE;
            rr_last_r <= RR_TX;
            arvalid_r <= 1'b0;
            araddr_r  <= 4'h0;
            rready_r  <= 1'b0;
            awvalid_r <= 1'b0;
            awaddr_r  <= 4'h0;
            wvalid_r  <= 1'b0;
            wdata_r   <= 32'h0;
            bready_r  <= 1'b0;
            axi_err_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            rr_last_r <= rr_last_s;
            arvalid_r <= arvalid_s;
            araddr_r  <= araddr_s;
            rready_r  <= rready_s;
            awvalid_r <= awvalid_s;
            awaddr_r  <= awaddr_s;
            wvalid_r  <= wvalid_s;
            wdata_r   <= wdata_s;
            bready_r  <= bready_s;
            axi_err_r <= axi_err_r | err_s;
        end
    end

    assign m_axi_araddr  = araddr_r;
    assign m_axi_arvalid = arvalid_r;
    assign m_axi_rready  = rready_r;
    assign m_axi_awaddr  = awaddr_r;
    assign m_axi_awvalid = awvalid_r;
    assign m_axi_wdata   = wdata_r;
    assign m_axi_wstrb   = 4'hF;
    assign m_axi_wvalid  = wvalid_r;
    assign m_axi_bready  = bready_r;
    assign rx_valid      = ~rx_empty_s;
    assign tx_ready      = ~tx_full_s;
    assign axi_err       = axi_err_r;

endmodule

// File: tb/tb_uart_axi_bridge.sv
// Directed bench for uart_axi_bridge with a UART Lite slave model and RX/TX scoreboards.
module tb_uart_axi_bridge;

    logic        clk = 1'b0;
    logic        rstn;
    logic [3:0]  m_axi_araddr, m_axi_awaddr, m_axi_wstrb;
    logic        m_axi_arvalid, m_axi_arready, m_axi_rvalid, m_axi_rready;
    logic [31:0] m_axi_rdata, m_axi_wdata;
    logic [1:0]  m_axi_rresp, m_axi_bresp;
    logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
    logic        m_axi_bvalid, m_axi_bready;
    logic        rx_valid, rx_pop, tx_ready, tx_push, axi_err;
    logic [7:0]  rx_data, tx_data;
    logic [2:0]  rx_level, tx_level;

    typedef struct packed {
        logic        wr;
        logic [3:0]  addr;
        logic [31:0] data;
    } txn_t;

    int          errors = 0;
    int          checks = 0;
    txn_t        log_q[$];
    logic [7:0]  rx_src[$];
    logic [7:0]  exp_rx[$];
    logic [7:0]  exp_tx[$];
    bit          force_rx = 1'b0, tx_full_f = 1'b0, hold = 1'b0, stall_aw = 1'b0;
    logic [1:0]  bresp_val = 2'b00;
    int          ctrl_writes = 0;
    bit          have_first_wr = 1'b0;
    txn_t        first_wr;

    uart_axi_bridge #(.RX_DEPTH(4), .TX_DEPTH(4), .DATA_W(8)) dut (
        .clk(clk), .rstn(rstn),
        .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
        .m_axi_rready(m_axi_rready), .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid),
        .m_axi_awready(m_axi_awready), .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp),
        .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_pop(rx_pop),
        .tx_ready(tx_ready), .tx_data(tx_data), .tx_push(tx_push),
        .rx_level(rx_level), .tx_level(tx_level), .axi_err(axi_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int count_txn(input logic wr, input logic [3:0] addr);
        int n = 0;
        foreach (log_q[i]) begin
            if (log_q[i].wr == wr && log_q[i].addr == addr) n++;
        end
        return n;
    endfunction

    function automatic logic [31:0] slave_read(input logic [3:0] addr);
        logic [31:0] v = 32'h0;
        if (addr == 4'h8) begin
            if (hold) v = 32'h0000_0008;
            else v = {28'h0, tx_full_f, 2'b00, force_rx | (rx_src.size() != 0)};
        end else if (addr == 4'h0) begin
            if (rx_src.size() != 0) v = {24'h0, rx_src.pop_front()};
        end
        return v;
    endfunction

    // UART Lite slave model: everything is driven on the falling edge
    initial begin
        bit ar_hs = 0, r_hs = 0, aw_hs = 0, w_hs = 0, b_hs = 0, aw_got = 0, w_got = 0;
        logic [3:0]  ar_addr = 4'h0, aw_addr = 4'h0;
        logic [31:0] w_dat = 32'h0;
        m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rdata = 32'h0; m_axi_rresp = 2'b00;
        m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_awready = 1'b0;
                m_axi_wready = 1'b0; m_axi_bvalid = 1'b0;
                ar_hs = 0; r_hs = 0; aw_hs = 0; w_hs = 0; b_hs = 0; aw_got = 0; w_got = 0;
            end else begin
                if (r_hs) m_axi_rvalid = 1'b0;
                if (ar_hs) begin
                    m_axi_rdata  = slave_read(ar_addr);
                    m_axi_rresp  = 2'b00;
                    m_axi_rvalid = 1'b1;
                    log_q.push_back('{wr: 1'b0, addr: ar_addr, data: m_axi_rdata});
                end
                if (b_hs) m_axi_bvalid = 1'b0;
                if (aw_hs) aw_got = 1;
                if (w_hs) w_got = 1;
                if (aw_got && w_got) begin
                    aw_got = 0; w_got = 0;
                    m_axi_bvalid = 1'b1;
                    m_axi_bresp  = bresp_val;
                    log_q.push_back('{wr: 1'b1, addr: aw_addr, data: w_dat});
                    if (!have_first_wr) begin
                        first_wr = '{wr: 1'b1, addr: aw_addr, data: w_dat};
                        have_first_wr = 1'b1;
                    end
                    if (aw_addr == 4'hC) ctrl_writes++;
                    if (aw_addr == 4'h4) begin
                        chk("tx_write_expected", 32'(exp_tx.size() != 0), 32'd1);
                        if (exp_tx.size() != 0) chk("tx_wdata", w_dat, {24'h0, exp_tx.pop_front()});
                    end
                end
                m_axi_arready = m_axi_arvalid;
                m_axi_awready = m_axi_awvalid & ~stall_aw;
                m_axi_wready  = m_axi_wvalid & ~stall_aw;
                ar_hs = m_axi_arvalid & m_axi_arready;
                if (ar_hs) ar_addr = m_axi_araddr;
                r_hs  = m_axi_rvalid & m_axi_rready;
                aw_hs = m_axi_awvalid & m_axi_awready;
                if (aw_hs) aw_addr = m_axi_awaddr;
                w_hs  = m_axi_wvalid & m_axi_wready;
                if (w_hs) begin
                    w_dat = m_axi_wdata;
                    chk("wstrb", 32'(m_axi_wstrb), 32'hF);
                end
                b_hs  = m_axi_bvalid & m_axi_bready;
            end
        end
    end

    task automatic pop_rx_check(input string tag);
        chk(tag, 32'(rx_data), (exp_rx.size() != 0) ? {24'h0, exp_rx.pop_front()} : 32'hDEAD);
        rx_pop = 1'b1;
        @(negedge clk);
        rx_pop = 1'b0;
    endtask

    task automatic push_tx(input logic [7:0] d, input bit expect_accept);
        tx_data = d;
        tx_push = 1'b1;
        if (expect_accept) exp_tx.push_back(d);
        @(negedge clk);
        tx_push = 1'b0;
    endtask

    initial begin
        logic [3:0] order[$];
        rstn = 1'b0; rx_pop = 1'b0; tx_push = 1'b0; tx_data = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset_valids", 32'({m_axi_arvalid, m_axi_rready, m_axi_awvalid, m_axi_wvalid, m_axi_bready}), 32'h0);
        chk("reset_addr_wdata", {m_axi_araddr, m_axi_awaddr, m_axi_wdata[23:0]}, 32'h0);
        chk("reset_levels", 32'({rx_level, tx_level, axi_err, rx_valid, tx_ready}), 32'h1);
        rstn = 1'b1;

`ifdef UART_CTRL_INIT_EN
        for (int i = 0; i < 50 && !have_first_wr; i++) @(negedge clk);
        chk("ctrl_first_wr_addr", 32'(first_wr.addr), 32'hC);
        chk("ctrl_first_wr_data", first_wr.data, 32'h3);
`endif

        // Single RX character
        rx_src.push_back(8'h41); exp_rx.push_back(8'h41);
        for (int i = 0; i < 100 && !rx_valid; i++) @(negedge clk);
        chk("rx_valid_rise", 32'(rx_valid), 32'd1);
        chk("rx_level_one", 32'(rx_level), 32'd1);
        pop_rx_check("rx_data_41");
        chk("rx_empty_after_pop", 32'({rx_valid, rx_level}), 32'h0);
        rx_pop = 1'b1; @(negedge clk); rx_pop = 1'b0;
        chk("rx_pop_on_empty", 32'(rx_level), 32'd0);

        // RX fill to capacity with STAT always reporting data
        log_q.delete();
        for (int k = 0; k < 4; k++) begin
            rx_src.push_back(8'h10 + 8'(k)); exp_rx.push_back(8'h10 + 8'(k));
        end
        force_rx = 1'b1;
        repeat (100) @(negedge clk);
        chk("rx_full_reads", 32'(count_txn(1'b0, 4'h0)), 32'd4);
        chk("rx_full_level", 32'(rx_level), 32'd4);
        chk("rx_full_last_is_stat", 32'(log_q[log_q.size()-1].addr), 32'h8);
        force_rx = 1'b0;
        repeat (10) @(negedge clk);
        for (int k = 0; k < 4; k++) pop_rx_check("rx_fifo_order");

        // TX two characters
        log_q.delete();
        push_tx(8'h55, 1'b1);
        push_tx(8'hAA, 1'b1);
        chk("tx_level_two", 32'(tx_level), 32'd2);
        for (int i = 0; i < 200 && tx_level != 3'd0; i++) @(negedge clk);
        chk("tx_drained", 32'(tx_level), 32'd0);
        chk("tx_write_count", 32'(count_txn(1'b1, 4'h4)), 32'd2);
        chk("tx_sb_empty", 32'(exp_tx.size()), 32'd0);

        // TX held off by UART TX_FULL; fifth push rejected at capacity
        tx_full_f = 1'b1;
        repeat (10) @(negedge clk);
        log_q.delete();
        for (int k = 0; k < 5; k++) push_tx(8'h70 + 8'(k), k < 4);
        chk("tx_full_level", 32'({tx_ready, tx_level}), 32'd4);
        repeat (40) @(negedge clk);
        chk("tx_no_write_when_full", 32'(count_txn(1'b1, 4'h4)), 32'd0);
        tx_full_f = 1'b0;
        for (int i = 0; i < 300 && tx_level != 3'd0; i++) @(negedge clk);
        chk("tx_full_drained", 32'(exp_tx.size()), 32'd0);

        // Round robin with both directions pending
        hold = 1'b1;
        repeat (10) @(negedge clk);
        push_tx(8'h61, 1'b1);
        push_tx(8'h62, 1'b1);
        rx_src.push_back(8'h31); exp_rx.push_back(8'h31);
        rx_src.push_back(8'h32); exp_rx.push_back(8'h32);
        repeat (5) @(negedge clk);
        log_q.delete();
        hold = 1'b0;
        for (int i = 0; i < 300 && !(tx_level == 3'd0 && rx_level == 3'd2); i++) @(negedge clk);
        foreach (log_q[i]) begin
            if ((!log_q[i].wr && log_q[i].addr == 4'h0) || (log_q[i].wr && log_q[i].addr == 4'h4))
                order.push_back(log_q[i].addr);
        end
        chk("rr_count", 32'(order.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < order.size()) chk("rr_order", 32'(order[i]), (i % 2 == 0) ? 32'h0 : 32'h4);
        end
        pop_rx_check("rr_rx_data");
        pop_rx_check("rr_rx_data");

        // Write error response
        chk("axi_err_clear", 32'(axi_err), 32'd0);
        bresp_val = 2'b10;
        push_tx(8'h99, 1'b1);
        for (int i = 0; i < 200 && tx_level != 3'd0; i++) @(negedge clk);
        chk("err_tx_popped", 32'(tx_level), 32'd0);
        chk("axi_err_set", 32'(axi_err), 32'd1);
        bresp_val = 2'b00;
        push_tx(8'h5A, 1'b1);
        for (int i = 0; i < 200 && tx_level != 3'd0; i++) @(negedge clk);
        chk("axi_err_sticky", 32'({axi_err, tx_level}), 32'h8);
`ifndef UART_CTRL_INIT_EN
        chk("no_ctrl_writes", 32'(ctrl_writes), 32'd0);
`endif

        // Reset in the middle of a stalled TX write
        stall_aw = 1'b1;
        push_tx(8'hEE, 1'b0);
        for (int i = 0; i < 100 && !m_axi_awvalid; i++) @(negedge clk);
        chk("stall_awvalid", 32'(m_axi_awvalid), 32'd1);
        rstn = 1'b0;
        @(negedge clk);
        chk("midreset_valids", 32'({m_axi_arvalid, m_axi_rready, m_axi_awvalid, m_axi_wvalid, m_axi_bready}), 32'h0);
        chk("midreset_state", 32'({rx_level, tx_level, axi_err}), 32'h0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        stall_aw = 1'b0;
        log_q.delete();
        repeat (40) @(negedge clk);
        chk("no_replay_after_reset", 32'(count_txn(1'b1, 4'h4)), 32'd0);
        chk("rx_sb_empty", 32'(exp_rx.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
